div_scheduler: RTL and testbench

DIV_SCHEDULER -- requirements
Module: div_scheduler

---
 rtl/div_sched_pkg.sv | 12 +
 rtl/prog_clock_divider.sv | 34 +++
 rtl/div_scheduler.sv | 82 ++++++++
 tb/tb_div_scheduler.sv | 112 +++++++++++
 4 files changed

// File: rtl/div_sched_pkg.sv
// Shared FSM encoding and default widths for the divided-clock job scheduler.
package div_sched_pkg;
  localparam int COUNT_WIDTH_DEF  = 4;
  localparam int CYCLES_WIDTH_DEF = 8;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE = 2'd0;
  localparam fsm_state_t ST_LOAD = 2'd1;
  localparam fsm_state_t ST_RUN  = 2'd2;
  localparam fsm_state_t ST_DONE = 2'd3;
endpackage

// File: rtl/prog_clock_divider.sv
// Programmable half-period divider: out toggles every div+1 enabled cycles.
module prog_clock_divider #(
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] div,
  output logic                   out,
  output logic                   period_tick
);
  logic [COUNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (load) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (en) begin
      if (cnt == div) begin
        cnt <= '0;
        out <= ~out;
      end else begin
        cnt <= cnt + COUNT_WIDTH'(1);
      end
    end
  end

  // High at the edge where out falls, i.e. one full period has elapsed.
  assign period_tick = en && (cnt == div) && out;
endmodule

// File: rtl/div_scheduler.sv
// Two-requester round-robin scheduler that runs one divided-clock job at a time.
module div_scheduler
  import div_sched_pkg::*;
#(
  parameter int COUNT_WIDTH  = COUNT_WIDTH_DEF,
  parameter int CYCLES_WIDTH = CYCLES_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  input  logic [COUNT_WIDTH-1:0]  div0,
  input  logic [COUNT_WIDTH-1:0]  div1,
  input  logic [CYCLES_WIDTH-1:0] ncyc0,
  input  logic [CYCLES_WIDTH-1:0] ncyc1,
  output logic [1:0]              ack,
  output logic                    busy,
  output logic                    grant_id,
  output logic                    out,
  output logic                    done
);
  fsm_state_t              state;
  logic                    prio;
  logic                    win;
  logic [COUNT_WIDTH-1:0]  div_l;
  logic [CYCLES_WIDTH-1:0] ncyc_l;
  logic [CYCLES_WIDTH-1:0] pcnt;
  logic                    period_tick;

  // prio names the favoured requester; it only matters when both request.
  always_comb begin
    win = prio;
    if (req == 2'b01)      win = 1'b0;
    else if (req == 2'b10) win = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      prio     <= 1'b0;
      grant_id <= 1'b0;
      div_l    <= '0;
      ncyc_l   <= '0;
      pcnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req != 2'b00) begin
          state    <= ST_LOAD;
          grant_id <= win;
          div_l    <= win ? div1 : div0;
          ncyc_l   <= win ? ncyc1 : ncyc0;
        end
        ST_LOAD: begin
          pcnt  <= '0;
          state <= (ncyc_l != '0) ? ST_RUN : ST_DONE;
        end
        ST_RUN: if (period_tick) begin
          pcnt <= pcnt + CYCLES_WIDTH'(1);
          if (pcnt == ncyc_l - CYCLES_WIDTH'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          prio  <= ~grant_id;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ack  = (state == ST_LOAD) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  prog_clock_divider #(.COUNT_WIDTH(COUNT_WIDTH)) u_div (
    .clk         (clk),
    .rst         (rst),
    .en          (state == ST_RUN),
    .load        (state == ST_LOAD),
    .div         (div_l),
    .out         (out),
    .period_tick (period_tick)
  );
endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler: reset, single job, contention, corners, abort.
module tb_div_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] div0 = '0, div1 = '0;
  logic [7:0] ncyc0 = '0, ncyc1 = '0;
  logic [1:0] ack;
  logic       busy, grant_id, out, done;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_scheduler dut (
    .clk(clk), .rst(rst), .req(req),
    .div0(div0), .div1(div1), .ncyc0(ncyc0), .ncyc1(ncyc1),
    .ack(ack), .busy(busy), .grant_id(grant_id), .out(out), .done(done)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Assumes the next edge takes IDLE->LOAD; walks LOAD, RUN, DONE and one IDLE cycle.
  task automatic job_check(input logic id, input int d, input int n,
                           input logic [1:0] req_after, input bit mutate);
    int   run_len;
    logic e;
    run_len = 2 * (d + 1) * n;
    cyc();
    chk("load", {ack, busy, done, out, grant_id},
        {(id ? 2'b10 : 2'b01), 1'b1, 1'b0, 1'b0, id});
    req = req_after;
    for (int i = 0; i < run_len; i++) begin
      cyc();
      e = ((i / (d + 1)) % 2) == 1;
      chk("run", {ack, busy, done, out}, {2'b00, 1'b1, 1'b0, e});
      if (mutate && i == 3) begin
        div0 = 4'd6; ncyc0 = 8'd9; req = 2'b10;
      end
      if (mutate && i == 4) req = 2'b00;
    end
    cyc();
    chk("done", {ack, busy, done, out, grant_id}, {2'b00, 1'b1, 1'b1, 1'b0, id});
    cyc();
    chk("idle", {ack, busy, done, out}, 5'b0);
  endtask

  initial begin
    // Reset held with both requesting
    req = 2'b11; div0 = 4'd5; ncyc0 = 8'd3;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("reset", {ack, busy, done, out, grant_id}, 6'b0);
    end
    rst = 1'b1; req = 2'b00;
    cyc();
    chk("post_reset_idle", {ack, busy, done, out, grant_id}, 6'b0);

    // Single job: div 5, 3 periods -> 36 RUN cycles
    req = 2'b01; div0 = 4'd5; ncyc0 = 8'd3;
    job_check(1'b0, 5, 3, 2'b00, 1'b0);

    // div 0: toggles every cycle; sole requester wins despite priority on 1
    req = 2'b01; div0 = 4'd0; ncyc0 = 8'd4;
    job_check(1'b0, 0, 4, 2'b00, 1'b0);

    // ncyc 0: done right after LOAD, no toggles
    req = 2'b10; div1 = 4'd7; ncyc1 = 8'd0;
    job_check(1'b1, 7, 0, 2'b00, 1'b0);

    // Contention: grants alternate starting at 0, back-to-back latency
    req = 2'b11; div0 = 4'd1; div1 = 4'd1; ncyc0 = 8'd2; ncyc1 = 8'd2;
    job_check(1'b0, 1, 2, 2'b11, 1'b0);
    job_check(1'b1, 1, 2, 2'b11, 1'b0);
    job_check(1'b0, 1, 2, 2'b11, 1'b0);
    job_check(1'b1, 1, 2, 2'b00, 1'b0);

    // Mid-job div/ncyc change and a transient req are ignored
    req = 2'b01; div0 = 4'd2; ncyc0 = 8'd2;
    job_check(1'b0, 2, 2, 2'b00, 1'b1);
    cyc();
    chk("no_stray_grant", {ack, busy}, 3'b0);

    // Abort in RUN cycle 12, then re-grant to requester 1
    req = 2'b10; div1 = 4'd3; ncyc1 = 8'd10;
    cyc();
    chk("abort_load", {ack, busy, grant_id}, {2'b10, 1'b1, 1'b1});
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("abort_run", {done, out}, {1'b0, 1'(((i / 4) % 2) == 1)});
    end
    rst = 1'b0;
    cyc();
    chk("abort_reset", {ack, busy, done, out, grant_id}, 6'b0);
    rst = 1'b1;
    job_check(1'b1, 3, 10, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
